// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the run_monitor block.
// Optional PC signature feature is enabled by defining RUN_MONITOR_SIG_EN.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        RM_IDLE    = 2'd0,
        RM_RUN     = 2'd1,
        RM_DONE    = 2'd2,
        RM_TIMEOUT = 2'd3
    } run_state_e;

    localparam int SIG_W = 32;

    // One signature step: rotate left by one, then fold in the retired PC.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] pc);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ pc;
    endfunction

endpackage

// File: rtl/run_monitor_halt_det.sv
// Jump-to-self detector: tracks the last retired PC and how many consecutive
// retires hit it, and flags the retire that brings the count to HALT_REPEAT.
module run_monitor_halt_det #(
    parameter int PC_W        = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            retire,
    input  logic [PC_W-1:0] pc,
    output logic            halt
);
    import run_monitor_pkg::*;

    logic [3:0]      rep_cnt_q, rep_cnt_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic [3:0]      rep_next;

    // Repeat-count update; cycles without a retire leave the history untouched.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        last_pc_d = last_pc_q;
        rep_next  = 4'd1;
        if ((pc == last_pc_q) && (rep_cnt_q != 4'd0)) begin
            rep_next = rep_cnt_q + 4'd1;
        end
        if (clear) begin
            rep_cnt_d = 4'd0;
            last_pc_d = '0;
        end else if (retire) begin
            rep_cnt_d = rep_next;
            last_pc_d = pc;
        end
        halt = retire && !clear && (rep_next == 4'(HALT_REPEAT));
    end

    // History registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= 4'd0;
            last_pc_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            last_pc_q <= last_pc_d;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run controller / watchdog beside the core: counts RUN cycles and retires,
// declares DONE on a jump-to-self, TIMEOUT after TIMEOUT_CYCLES, and latches
// a result snapshot. Define RUN_MONITOR_SIG_EN to enable the PC signature.
module run_monitor #(
    parameter int PC_W           = 32,
    parameter int CNT_W          = 32,
    parameter int RES_W          = 32,
    parameter int HALT_REPEAT    = 4,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_insn_vld,
    input  logic [RES_W-1:0] i_result,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_insn_cnt,
    output logic [PC_W-1:0]  o_halt_pc,
    output logic [RES_W-1:0] o_result,
    output logic [31:0]      o_pc_sig
);
    import run_monitor_pkg::*;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] insn_cnt_q, insn_cnt_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             run_start;
    logic             retire;
    logic             halt;

    assign retire = (state_q == RM_RUN) && i_insn_vld;

    run_monitor_halt_det #(
        .PC_W        (PC_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_det (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .clear  (run_start),
        .retire (retire),
        .pc     (i_pc),
        .halt   (halt)
    );

    // Next-state and counter/snapshot update; halt takes priority over timeout.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        insn_cnt_d  = insn_cnt_q;
        halt_pc_d   = halt_pc_q;
        result_d    = result_q;
        run_start   = 1'b0;
        case (state_q)
            RM_IDLE: begin
                if (i_start) begin
                    state_d     = RM_RUN;
                    cycle_cnt_d = '0;
                    insn_cnt_d  = '0;
                    halt_pc_d   = '0;
                    result_d    = '0;
                    run_start   = 1'b1;
                end
            end
            RM_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                if (i_insn_vld && (insn_cnt_q != '1)) begin
                    insn_cnt_d = insn_cnt_q + CNT_W'(1);
                end
                if (halt) begin
                    state_d   = RM_DONE;
                    halt_pc_d = i_pc;
                    result_d  = i_result;
                end else if (cycle_cnt_q == TO_LAST) begin
                    state_d  = RM_TIMEOUT;
                    result_d = i_result;
                end
            end
            RM_DONE, RM_TIMEOUT: begin
                if (i_clear) begin
                    state_d = RM_IDLE;
                end
            end
            default: state_d = RM_IDLE;
        endcase
    end

    // State, counters and snapshots.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= RM_IDLE;
            cycle_cnt_q <= '0;
            insn_cnt_q  <= '0;
            halt_pc_q   <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            insn_cnt_q  <= insn_cnt_d;
            halt_pc_q   <= halt_pc_d;
            result_q    <= result_d;
        end
    end

`ifdef RUN_MONITOR_SIG_EN
    logic [SIG_W-1:0] sig_q, sig_d;

    // Signature folds in every RUN retire and restarts with each run.
    always_comb begin
        sig_d = sig_q;
        if (run_start) begin
            sig_d = '0;
        end else if (retire) begin
            sig_d = sig_step(sig_q, SIG_W'(i_pc));
        end
    end

    // Signature register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign o_pc_sig = sig_q;
`else
    assign o_pc_sig = 32'd0;
`endif

    assign o_busy      = (state_q == RM_RUN);
    assign o_done      = (state_q == RM_DONE);
    assign o_timeout   = (state_q == RM_TIMEOUT);
    assign o_cycle_cnt = cycle_cnt_q;
    assign o_insn_cnt  = insn_cnt_q;
    assign o_halt_pc   = halt_pc_q;
    assign o_result    = result_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed scenarios plus randomized
// traffic, all compared against a retire-history reference model.
module tb_run_monitor;

    localparam int HR = 4;
    localparam int TO = 20;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_clear = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_insn_vld = 1'b0;
    logic [31:0] i_result = '0;
    logic        o_busy, o_done, o_timeout;
    logic [31:0] o_cycle_cnt, o_insn_cnt, o_halt_pc, o_result, o_pc_sig;

    int assert_count = 0;
    int fail_count   = 0;

    // Reference model: run status, counters, snapshots and the list of PCs
    // retired so far in the current run.
    bit          m_running, m_done, m_timeout;
    longint      m_cycles, m_insns;
    logic [31:0] m_halt_pc, m_result, m_sig;
    logic [31:0] m_hist[$];

    run_monitor #(
        .PC_W           (32),
        .CNT_W          (32),
        .RES_W          (32),
        .HALT_REPEAT    (HR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_clear     (i_clear),
        .i_pc        (i_pc),
        .i_insn_vld  (i_insn_vld),
        .i_result    (i_result),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_cycle_cnt (o_cycle_cnt),
        .o_insn_cnt  (o_insn_cnt),
        .o_halt_pc   (o_halt_pc),
        .o_result    (o_result),
        .o_pc_sig    (o_pc_sig)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got stuck, required finish");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_running = 0; m_done = 0; m_timeout = 0;
        m_cycles = 0; m_insns = 0;
        m_halt_pc = '0; m_result = '0; m_sig = '0;
        m_hist.delete();
    endtask

    // Halt means the last HR retires of this run were all at one PC.
    function automatic bit modelHalted();
        int n = m_hist.size();
        if (n < HR) return 0;
        for (int i = 1; i < HR; i++) begin
            if (m_hist[n-1-i] != m_hist[n-1]) return 0;
        end
        return 1;
    endfunction

    task automatic modelStep(input bit start, input bit clear, input bit vld,
                             input logic [31:0] pc, input logic [31:0] res);
        longint pre_cycles;
        if (m_running) begin
            pre_cycles = m_cycles;
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
            if (vld) begin
                if (m_insns < 64'hFFFF_FFFF) m_insns++;
                m_hist.push_back(pc);
`ifdef RUN_MONITOR_SIG_EN
                m_sig = {m_sig[30:0], m_sig[31]} ^ pc;
`endif
            end
            if (vld && modelHalted()) begin
                m_running = 0; m_done = 1;
                m_halt_pc = pc; m_result = res;
            end else if (pre_cycles == TO - 1) begin
                m_running = 0; m_timeout = 1;
                m_result = res;
            end
        end else if (m_done || m_timeout) begin
            if (clear) begin
                m_done = 0; m_timeout = 0;
            end
        end else if (start) begin
            m_running = 1;
            m_cycles = 0; m_insns = 0;
            m_halt_pc = '0; m_result = '0; m_sig = '0;
            m_hist.delete();
        end
    endtask

    task automatic compareAll();
        checkOutput("busy",      o_busy,      m_running);
        checkOutput("done",      o_done,      m_done);
        checkOutput("timeout",   o_timeout,   m_timeout);
        checkOutput("cycle_cnt", o_cycle_cnt, m_cycles);
        checkOutput("insn_cnt",  o_insn_cnt,  m_insns);
        checkOutput("halt_pc",   o_halt_pc,   m_halt_pc);
        checkOutput("result",    o_result,    m_result);
        checkOutput("pc_sig",    o_pc_sig,    m_sig);
    endtask

    task automatic applyStimulus(input bit start, input bit clear, input bit vld,
                                 input logic [31:0] pc, input logic [31:0] res);
        @(negedge i_clk);
        i_start = start; i_clear = clear; i_insn_vld = vld; i_pc = pc; i_result = res;
        modelStep(start, clear, vld, pc, res);
        @(posedge i_clk);
        #1;
        compareAll();
    endtask

    // Asynchronous reset assertion, checked before any clock edge arrives.
    task automatic doReset();
        @(negedge i_clk);
        #2;
        i_reset = 1'b0;
        i_start = 0; i_clear = 0; i_insn_vld = 0;
        modelReset();
        #1;
        compareAll();
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        logic [31:0] pcs[3];
        logic [31:0] prev_pc;
        logic [31:0] rpc;
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
        $display("[TB] run_monitor bench start");
        i_reset = 1'b1;
        doReset();

        // Straight-line program ending in a jump-to-self at 0xC.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h0, 32'h55);
        applyStimulus(0, 0, 1, 32'h4, 32'h55);
        applyStimulus(0, 0, 1, 32'h8, 32'h55);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'hC, 32'h55);
        checkOutput("t1_done",    o_done,     1);
        checkOutput("t1_halt_pc", o_halt_pc,  32'hC);
        checkOutput("t1_insn",    o_insn_cnt, 7);
        checkOutput("t1_result",  o_result,   32'h55);
        applyStimulus(1, 0, 1, 32'hC, 0);
        checkOutput("t1_sticky",  o_done,     1);
        applyStimulus(0, 1, 0, 0, 0);

        // Never-repeating PCs run into the timeout.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) applyStimulus(0, 0, 1, 32'(i * 4), 32'hA0 + 32'(i));
        checkOutput("t2_timeout", o_timeout,   1);
        checkOutput("t2_cycles",  o_cycle_cnt, TO);
        checkOutput("t2_done",    o_done,      0);
        applyStimulus(0, 1, 0, 0, 0);

        // Gap cycles do not break the repeat count.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'h10, 32'h3);
        applyStimulus(0, 0, 0, 32'h10, 32'h3);
        applyStimulus(0, 0, 1, 32'h10, 32'h3);
        checkOutput("t3_done", o_done, 1);
        applyStimulus(0, 1, 0, 0, 0);

        // A different PC restarts the repeat count.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h10, 1);
        applyStimulus(0, 0, 1, 32'h10, 1);
        applyStimulus(0, 0, 1, 32'h14, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'h10, 1);
        checkOutput("t4_no_halt", o_done, 0);
        applyStimulus(0, 0, 1, 32'h10, 2);
        checkOutput("t4_done", o_done, 1);
        applyStimulus(0, 1, 0, 0, 0);

        // Halt retire on the last allowed cycle beats the timeout.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < TO - HR; i++) applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < HR; i++) applyStimulus(0, 0, 1, 32'h20, 32'h77);
        checkOutput("t5_done",    o_done,    1);
        checkOutput("t5_timeout", o_timeout, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Reset mid-run, then a clean run.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h40, 9);
        applyStimulus(0, 0, 1, 32'h44, 9);
        doReset();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h4, 1);
        applyStimulus(0, 0, 1, 32'h8, 1);
        applyStimulus(0, 0, 1, 32'h8, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic with mostly repeating PCs.
        prev_pc = pcs[0];
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                rpc = ($urandom_range(0, 2) == 0) ? pcs[$urandom_range(0, 2)] : prev_pc;
                prev_pc = rpc;
                applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                              $urandom_range(0, 3) != 0, rpc, $urandom());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
